// File: rtl/bus_grant_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus. A dead turnaround cycle separates
// owners, and the resolved bus value is captured as each tenure ends.
module bus_grant_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    input  logic [DATA_W-1:0] bus_in,
    output logic [N_REQ-1:0]  grant,
    output logic [2:0]        owner,
    output logic              busy,
    output logic [DATA_W-1:0] bus_capture,
    output logic              capture_valid,
    output logic              timeout
);

    typedef enum logic [1:0] {StIdle, StTurn, StGrant} state_e;

    state_e            state_q;
    logic [N_REQ-1:0]  grant_q;
    logic [2:0]        owner_q;
    logic              busy_q;
    logic [DATA_W-1:0] capture_q;
    logic              cap_valid_q;
    logic              timeout_q;
    logic [7:0]        hold_q;

    logic [N_REQ-1:0]  own_mask;
    logic [N_REQ-1:0]  others;
    logic              own_req;
    logic              own_done;
    logic              hold_max;
    logic              tenure_end;
    logic [2:0]        win_any;
    logic [2:0]        win_other;

    // First set bit of mask searching last+1, last+2, ... modulo N_REQ; last itself comes last.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] mask, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 4'(last) + 4'(i) + 4'd1;
            if (idx >= 4'(N_REQ)) begin
                idx = idx - 4'(N_REQ);
            end
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!found && idx == 4'(j) && mask[j]) begin
                    pick  = 3'(j);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    always_comb begin
        own_mask = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (owner_q == 3'(j)) begin
                own_mask[j] = 1'b1;
            end
        end
    end

    assign own_req    = |(req & own_mask);
    assign own_done   = |(done & own_mask);
    assign hold_max   = (hold_q == 8'(MAX_HOLD));
    assign tenure_end = own_done | ~own_req | hold_max;
    // Excluding the owner lets it win again only when nobody else is asking.
    assign others     = req & ~own_mask;
    assign win_any    = rr_pick(req, owner_q);
    assign win_other  = rr_pick(others, owner_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= 3'(N_REQ - 1);
            busy_q      <= 1'b0;
            capture_q   <= '0;
            cap_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= 8'd0;
        end else begin
            cap_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        owner_q <= win_any;
                        busy_q  <= 1'b1;
                        state_q <= StTurn;
                    end
                end
                StTurn: begin
                    if (own_req) begin
                        grant_q <= own_mask;
                        hold_q  <= 8'd1;
                        state_q <= StGrant;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (tenure_end) begin
                        // Driver is still enabled this cycle, so bus_in holds the owner's value.
                        capture_q   <= bus_in;
                        cap_valid_q <= 1'b1;
                        timeout_q   <= hold_max & own_req & ~own_done;
                        grant_q     <= '0;
                        hold_q      <= 8'd0;
                        if (|others) begin
                            owner_q <= win_other;
                            state_q <= StTurn;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign busy          = busy_q;
    assign bus_capture   = capture_q;
    assign capture_valid = cap_valid_q;
    assign timeout       = timeout_q;

endmodule
